output_mode_ctrl: RTL and testbench
===================================

Name: output_mode_ctrl

Overview:
Parametrised successor to the two-output mode FSM. It selects one of NUM_MODES-1 output drivers (PWM, R2R, and future ones) or OFF from a binary mode_select. mode_select is debounced (qualified) before use. Switching directly between two driver modes inserts a break-before-make dead time. It sits between the switch/UI logic and the output driver enables.

Parameters:
NUM_MODES, 3, total modes including OFF (code 0); legal range 2..16
SEL_WIDTH, $clog2(NUM_MODES), width of mode_select and active_mode
STABLE_CYCLES, 4, consecutive identical samples required to qualify mode_select (>=1)
DEAD_CYCLES, 2, all-off cycles inserted between two non-OFF modes (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
mode_select  in  SEL_WIDTH  requested mode; 0=OFF, 1=PWM, 2=R2R, ...
mode_enable  out  NUM_MODES-1  one-hot-or-zero enables; bit i-1 drives mode i
active_mode  out  SEL_WIDTH  mode currently driven (0 while OFF or in dead time)
switching  out  1  high during dead time
sel_invalid  out  1  high while the qualified request is an illegal code (>=NUM_MODES)

Behaviour:
- Reset (reset_n low at a clk edge): state ST_OFF, all outputs 0, qualifier candidate 0, counter 0, qualified mode 0. Reset takes effect mid-dead-time or mid-qualification with no residual state.
- Qualifier: mode_select is sampled every edge into a candidate register.
  - A sample that differs from the candidate reloads it and sets the count to 1.
  - An equal sample increments the count, saturating at STABLE_CYCLES.
  - qualified_mode is updated on the edge where the count reaches STABLE_CYCLES.
  - Example: new value held before edge 1, STABLE_CYCLES=4: qualified at edge 4. Glitches shorter than STABLE_CYCLES never qualify.
- Illegal qualified code: treated as OFF. sel_invalid is set on the same edge qualified_mode updates and stays high until a legal code qualifies.
- FSM states: ST_OFF, ST_ACTIVE, ST_DEAD.
  - ST_OFF, target!=0 -> ST_ACTIVE on the next edge after qualification. No dead time is needed from OFF.
  - ST_ACTIVE, target==0 -> ST_OFF on the next edge after qualification. Enables drop immediately.
  - ST_ACTIVE, target is a different non-OFF mode -> ST_DEAD. Enables all 0, switching=1, dead counter=DEAD_CYCLES-1.
  - ST_DEAD: counter decrements each edge. At 0 the FSM goes to ST_ACTIVE with the latest target.
  - ST_DEAD, target becomes 0 -> ST_OFF on the next edge, aborting the dead time.
  - ST_DEAD, target changes to another non-OFF mode: the counter is not restarted; the latest target is used at exit.
  - ST_DEAD, target returns to the mode that was active before the dead time: the full dead time still completes.
- Latency from a held mode_select change:
  - OFF<->mode: enable changes at edge STABLE_CYCLES+1.
  - mode->mode: old enable is low from edge STABLE_CYCLES+1; new enable is high from edge STABLE_CYCLES+1+DEAD_CYCLES.
- Outputs are registered (glitch-free).
  - mode_enable has at most one bit high, and never overlaps between modes.
  - active_mode equals the index of the set bit, or 0.
- Same mode re-qualified: no effect, no dead time.

Decomposition:
- Package output_mode_pkg:
  - state enum statetype {ST_OFF, ST_ACTIVE, ST_DEAD}
  - constant MODE_OFF = 0
  - function onehot_enable(mode, NUM_MODES) returning the enable vector
- Sub-module mode_select_qualifier (params SEL_WIDTH, STABLE_CYCLES):
  - ports: clk, reset_n, mode_select, qualified_mode, qualified_valid
  - qualified_valid is a 1-cycle strobe on update
- The top level holds the FSM, the dead counter and the output registers.

Test Plan:
- Reset then mode_select=1 held (STABLE=4, DEAD=2) -> mode_enable=2'b01, active_mode=1 from edge 5; zero before.
- From PWM active, mode_select=2 held -> mode_enable=00 and switching=1 after edge 5; 2'b10 and active_mode=2 after edge 7; never 2'b11.
- 3-cycle pulse mode_select 0->1->0 -> mode_enable stays 00 throughout, no switching.
- mode_select=3 with NUM_MODES=3 held 4 cycles -> sel_invalid=1 from edge 4, enables 00, active_mode=0; then mode_select=1 -> sel_invalid clears at qualification and PWM enables.
- During dead time (PWM->R2R), mode_select=0 qualifies -> ST_OFF next edge, switching=0, enables 00, R2R never asserted.
- reset_n=0 for one edge while R2R active or mid-dead -> all outputs 0 on that edge; after release, the held mode re-qualifies with full STABLE_CYCLES latency.

Source files
------------

// File: rtl/output_mode_ctrl_pkg.sv
// Shared types and helpers for the output mode controller: FSM state encoding
// and the mode-to-enable decode used by the output registers.
package output_mode_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ACTIVE,
    ST_DEAD
  } statetype;

  localparam int MODE_OFF    = 0;
  localparam int MODE_W      = 4;   // widest mode code (NUM_MODES <= 16)
  localparam int MAX_DRIVERS = 15;

  // Bit i-1 set for mode i; codes 0 and >= num_modes give all zeros.
  function automatic logic [MAX_DRIVERS-1:0] onehot_enable(input logic [MODE_W-1:0] mode,
                                                           input int num_modes);
    logic [MAX_DRIVERS-1:0] en;
    en = '0;
    for (int i = 1; i <= MAX_DRIVERS; i++) begin
      if (i < num_modes && mode == MODE_W'(i)) begin
        en[i-1] = 1'b1;
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/output_mode_ctrl_if.sv
// Bus between the switch/UI logic (master) and the output mode controller (slave).
interface output_mode_ctrl_if #(
  parameter int NUM_MODES = 3,
  parameter int SEL_WIDTH = $clog2(NUM_MODES)
);
  logic [SEL_WIDTH-1:0] mode_select;
  logic [NUM_MODES-2:0] mode_enable;
  logic [SEL_WIDTH-1:0] active_mode;
  logic                 switching;
  logic                 sel_invalid;

  modport master (
    output mode_select,
    input  mode_enable, active_mode, switching, sel_invalid
  );

  modport slave (
    input  mode_select,
    output mode_enable, active_mode, switching, sel_invalid
  );
endinterface

// File: rtl/output_mode_ctrl_qualifier.sv
// Debounces mode_select: a value must be sampled STABLE_CYCLES times in a row
// before it is published as qualified_mode, with a one-cycle update strobe.
module mode_select_qualifier #(
  parameter int SEL_WIDTH     = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SEL_WIDTH-1:0] mode_select,
  output logic [SEL_WIDTH-1:0] qualified_mode,
  output logic                 qualified_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

  logic [SEL_WIDTH-1:0] candidate_reg, candidate_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [SEL_WIDTH-1:0] qualified_reg;
  logic                 valid_reg;
  logic                 differs;
  logic                 reached;

  always_comb begin
    candidate_next = candidate_reg;
    count_next     = count_reg;
    differs        = (mode_select != candidate_reg);
    if (differs) begin
      candidate_next = mode_select;
      count_next     = CW'(1);
    end else if (count_reg != STABLE_C) begin
      count_next = count_reg + CW'(1);
    end
    // Fire only on the edge the count arrives at STABLE, not while it sits there.
    reached = (count_next == STABLE_C) && (differs || count_reg != STABLE_C);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      candidate_reg <= '0;
      count_reg     <= '0;
      qualified_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      candidate_reg <= candidate_next;
      count_reg     <= count_next;
      valid_reg     <= reached;
      if (reached) begin
        qualified_reg <= candidate_next;
      end
    end
  end

  assign qualified_mode  = qualified_reg;
  assign qualified_valid = valid_reg;

endmodule

// File: rtl/output_mode_ctrl.sv
// Output mode controller: qualified mode request drives one-hot driver enables,
// with break-before-make dead time between two driver modes.
module output_mode_ctrl
  import output_mode_pkg::*;
#(
  parameter int NUM_MODES     = 3,
  parameter int SEL_WIDTH     = $clog2(NUM_MODES),
  parameter int STABLE_CYCLES = 4,
  parameter int DEAD_CYCLES   = 2
) (
  input logic               clk,
  input logic               reset_n,
  output_mode_ctrl_if.slave bus
);

  localparam int ND = NUM_MODES - 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]        DEAD_LOAD   = DW'(DEAD_CYCLES - 1);
  localparam logic [SEL_WIDTH:0]   NUM_MODES_W = (SEL_WIDTH + 1)'(NUM_MODES);
  localparam logic [SEL_WIDTH-1:0] OFF_CODE    = SEL_WIDTH'(MODE_OFF);

  logic [SEL_WIDTH-1:0] qualified_mode;
  logic                 qualified_valid;
  logic                 invalid;
  logic [SEL_WIDTH-1:0] target;

  statetype             state_reg, state_next;
  logic [DW-1:0]        dead_reg, dead_next;
  logic [ND-1:0]        enable_reg, enable_next;
  logic [SEL_WIDTH-1:0] active_reg, active_next;
  logic                 switching_reg, switching_next;

  mode_select_qualifier #(
    .SEL_WIDTH     (SEL_WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_qualifier (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode_select     (bus.mode_select),
    .qualified_mode  (qualified_mode),
    .qualified_valid (qualified_valid)
  );

  // Illegal codes behave as OFF; the flag tracks the qualified register directly.
  assign invalid = ({1'b0, qualified_mode} >= NUM_MODES_W);
  assign target  = invalid ? OFF_CODE : qualified_mode;

  always_comb begin
    state_next     = state_reg;
    dead_next      = dead_reg;
    enable_next    = enable_reg;
    active_next    = active_reg;
    switching_next = 1'b0;
    case (state_reg)
      ST_OFF: begin
        if (qualified_valid && target != OFF_CODE) begin
          state_next  = ST_ACTIVE;
          enable_next = ND'(onehot_enable(MODE_W'(target), NUM_MODES));
          active_next = target;
        end
      end
      ST_ACTIVE: begin
        if (qualified_valid && target != active_reg) begin
          enable_next = '0;
          active_next = OFF_CODE;
          if (target == OFF_CODE) begin
            state_next = ST_OFF;
          end else begin
            state_next     = ST_DEAD;
            switching_next = 1'b1;
            dead_next      = DEAD_LOAD;
          end
        end
      end
      ST_DEAD: begin
        // Counter is never restarted; whatever target holds at expiry wins.
        if (target == OFF_CODE) begin
          state_next = ST_OFF;
        end else if (dead_reg == '0) begin
          state_next  = ST_ACTIVE;
          enable_next = ND'(onehot_enable(MODE_W'(target), NUM_MODES));
          active_next = target;
        end else begin
          dead_next      = dead_reg - DW'(1);
          switching_next = 1'b1;
        end
      end
      default: begin
        state_next  = ST_OFF;
        enable_next = '0;
        active_next = OFF_CODE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_OFF;
      dead_reg      <= '0;
      enable_reg    <= '0;
      active_reg    <= '0;
      switching_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dead_reg      <= dead_next;
      enable_reg    <= enable_next;
      active_reg    <= active_next;
      switching_reg <= switching_next;
    end
  end

  assign bus.mode_enable = enable_reg;
  assign bus.active_mode = active_reg;
  assign bus.switching   = switching_reg;
  assign bus.sel_invalid = invalid;

endmodule

// File: tb/tb_output_mode_ctrl.sv
// Bench for output_mode_ctrl: table of held mode_select phases with expected
// outputs, plus a long-dead-time instance for abort/return corner cases.
module tb_output_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sel = 2'd0;

  always #5 clk = ~clk;

  output_mode_ctrl_if #(.NUM_MODES(3)) bus ();
  output_mode_ctrl_if #(.NUM_MODES(3)) bus_l ();

  assign bus.mode_select   = sel;
  assign bus_l.mode_select = sel;

  output_mode_ctrl #(.NUM_MODES(3), .STABLE_CYCLES(4), .DEAD_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  output_mode_ctrl #(.NUM_MODES(3), .STABLE_CYCLES(4), .DEAD_CYCLES(8)) dut_long (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_l)
  );

  typedef struct {
    string      name;
    logic [1:0] sel;
    int         hold;
    logic [1:0] en;
    logic [1:0] act;
    logic       sw;
    logic       inv;
    bit         longdut;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   watch_pwm = 1'b0;
  bit   pwm_seen  = 1'b0;

  function automatic vec_t mk(string n, logic [1:0] s, int h, logic [1:0] en,
                              logic [1:0] a, logic sw, logic inv, bit l);
    vec_t v;
    v.name = n; v.sel = s; v.hold = h; v.en = en;
    v.act = a; v.sw = sw; v.inv = inv; v.longdut = l;
    return v;
  endfunction

  function automatic logic [1:0] act_of(logic [1:0] en);
    if (en == 2'b01) return 2'd1;
    if (en == 2'b10) return 2'd2;
    return 2'd0;
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(vec_t e);
    logic [1:0] en, act;
    logic       sw, inv;
    en  = e.longdut ? bus_l.mode_enable : bus.mode_enable;
    act = e.longdut ? bus_l.active_mode : bus.active_mode;
    sw  = e.longdut ? bus_l.switching   : bus.switching;
    inv = e.longdut ? bus_l.sel_invalid : bus.sel_invalid;
    tests++;
    if (en !== e.en || act !== e.act || sw !== e.sw || inv !== e.inv) begin
      fails++;
      $display("FAIL %s (dut%s): got en=%b act=%0d sw=%b inv=%b, want en=%b act=%0d sw=%b inv=%b",
               e.name, e.longdut ? "_long" : "", en, act, sw, inv, e.en, e.act, e.sw, e.inv);
    end else begin
      $display("ok   %s (dut%s): en=%b act=%0d sw=%b inv=%b",
               e.name, e.longdut ? "_long" : "", en, act, sw, inv);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    sel = v.sel;
    exp_q.push_back(v);
    tick(v.hold);
    e = exp_q.pop_front();
    check_out(e);
  endtask

  // Every cycle: enables one-hot-or-zero, active_mode matches, no enable in dead time.
  always @(negedge clk) begin
    if (reset_n) begin
      tests++;
      if (!$onehot0(bus.mode_enable) || bus.active_mode !== act_of(bus.mode_enable) ||
          (bus.switching && bus.mode_enable != 2'b00)) begin
        fails++;
        $display("FAIL invariant dut: en=%b act=%0d sw=%b", bus.mode_enable,
                 bus.active_mode, bus.switching);
      end
      tests++;
      if (!$onehot0(bus_l.mode_enable) || bus_l.active_mode !== act_of(bus_l.mode_enable) ||
          (bus_l.switching && bus_l.mode_enable != 2'b00)) begin
        fails++;
        $display("FAIL invariant dut_long: en=%b act=%0d sw=%b", bus_l.mode_enable,
                 bus_l.active_mode, bus_l.switching);
      end
      if (watch_pwm && bus_l.mode_enable[0]) pwm_seen = 1'b1;
    end
  end

  initial begin
    // name, sel, hold, en, act, sw, inv, longdut
    tbl.push_back(mk("reset",      2'd0, 0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("pwm_wait",   2'd1, 4, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("pwm_on",     2'd1, 1, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("r2r_hold",   2'd2, 4, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("dead_1",     2'd2, 1, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("dead_2",     2'd2, 1, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("r2r_on",     2'd2, 1, 2'b10, 2'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("off_wait",   2'd0, 4, 2'b10, 2'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("off",        2'd0, 1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("glitch",     2'd1, 3, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("glitch_end", 2'd0, 6, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("inv_wait",   2'd3, 3, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("inv_set",    2'd3, 1, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("inv_hold",   2'd3, 2, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("inv_clear",  2'd1, 4, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("pwm_back",   2'd1, 1, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("sel_glitch", 2'd2, 2, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("same_mode",  2'd1, 6, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("r2r_again",  2'd2, 7, 2'b10, 2'd2, 1'b0, 1'b0, 1'b0));

    reset_n = 1'b0;
    tick(2);
    apply(tbl[0]);
    reset_n = 1'b1;
    for (int i = 1; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // One-edge reset: dut has R2R active, dut_long is mid dead time.
    reset_n = 1'b0;
    tick(1);
    check_out(mk("rst_mid",      2'd2, 0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    check_out(mk("rst_mid_dead", 2'd2, 0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1));
    reset_n = 1'b1;
    apply(mk("requal_wait", 2'd2, 4, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0));
    tick(1);
    check_out(mk("requal_on",      2'd2, 0, 2'b10, 2'd2, 1'b0, 1'b0, 1'b0));
    check_out(mk("requal_on_long", 2'd2, 0, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1));

    // Abort a long dead time by qualifying OFF; PWM must never assert.
    watch_pwm = 1'b1;
    apply(mk("abort_dead",    2'd1, 5, 2'b00, 2'd0, 1'b1, 1'b0, 1'b1));
    apply(mk("abort_wait",    2'd0, 4, 2'b00, 2'd0, 1'b1, 1'b0, 1'b1));
    apply(mk("abort_off",     2'd0, 1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1));
    apply(mk("abort_settle",  2'd0, 8, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1));
    watch_pwm = 1'b0;
    tests++;
    if (pwm_seen) begin
      fails++;
      $display("FAIL abort_no_pwm: got pwm_seen=1, want 0");
    end else begin
      $display("ok   abort_no_pwm: pwm_seen=0");
    end

    // Returning to the previous mode mid dead time still waits the full dead time.
    apply(mk("ret_r2r_on",   2'd2, 5, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1));
    apply(mk("ret_dead",     2'd1, 5, 2'b00, 2'd0, 1'b1, 1'b0, 1'b1));
    apply(mk("ret_still",    2'd2, 7, 2'b00, 2'd0, 1'b1, 1'b0, 1'b1));
    apply(mk("ret_r2r_back", 2'd2, 1, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
